// File: rtl/fp_sqrt_pipe_if.sv
// Handshake and status bundle for fp_sqrt_pipe. The slave modport is the
// square-root unit and the master modport is whatever feeds it.
interface fp_sqrt_pipe_if #(
   parameter int W = 16
);
   // Valid/ready handshake: a word moves only on a rising edge where valid and
   // ready are both high. Once valid is raised, the producer holds it and the
   // data stable until that edge. Ready may depend on state but never on valid.
   logic         IN_VALID;
   logic         IN_READY;
   logic [W-1:0] IN_DATA;
   logic         OUT_VALID;
   logic         OUT_READY;
   logic [W-1:0] OUT_DATA;
   logic         IS_NAN;
   logic         IS_PINF;
   logic         IS_NINF;
   logic         BUSY;
   logic [2:0]   state_dbg;

   modport master (
      output IN_VALID, IN_DATA, OUT_READY,
      input  IN_READY, OUT_VALID, OUT_DATA, IS_NAN, IS_PINF, IS_NINF, BUSY, state_dbg
   );

   modport slave (
      input  IN_VALID, IN_DATA, OUT_READY,
      output IN_READY, OUT_VALID, OUT_DATA, IS_NAN, IS_PINF, IS_NINF, BUSY, state_dbg
   );
endinterface

// File: rtl/fp_sqrt_pipe.sv
// Multi-cycle IEEE-style floating-point square root, one result bit per cycle.
// Define FP_SQRT_ROUND_EN for round-to-nearest; the default build truncates.
module fp_sqrt_pipe #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic          CLK,
   input  logic          RST_N,
   fp_sqrt_pipe_if.slave bus
);
   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int QW   = MAN_W + 2;
   localparam int XW   = 2 * QW;
   localparam int RW   = MAN_W + 5;
   localparam int CW   = $clog2(QW + 1);
   localparam int SHW  = $clog2(MAN_W + 1);
   localparam int EW   = EXP_W + SHW + 2;
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;
   localparam logic [W-1:0] QNAN = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FP_SQRT_ROUND_EN
   localparam logic ROUND_EN = 1'b1;
`else
   localparam logic ROUND_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_CALC   = 3'd2,
      S_ROUND  = 3'd3,
      S_DONE   = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [W-1:0]     data_q, data_d;
   logic [XW-1:0]    rad_q, rad_d;
   logic [RW-1:0]    rem_q, rem_d;
   logic [QW-1:0]    root_q, root_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [EXP_W-1:0] exp_q, exp_d;
   logic [W-1:0]     out_data_q, out_data_d;
   logic             is_nan_q, is_nan_d;
   logic             is_pinf_q, is_pinf_d;

   logic             sign_w;
   logic [EXP_W-1:0] expf_w;
   logic [MAN_W-1:0] man_w;
   logic             exp_all1_w, exp_zero_w, man_zero_w;
   logic [SHW-1:0]   pos_w, sh_w;
   logic [MAN_W:0]   sig_w;
   logic [EW-1:0]    ue_w, ue_even_w, half_w;
   logic [QW-1:0]    rmant_w;
   logic [EXP_W-1:0] rexp_w;
   logic [RW-1:0]    r_sh_w, trial_w;
   logic [QW:0]      rnd_w;
   logic             unused_w;

   assign sign_w     = data_q[W-1];
   assign expf_w     = data_q[W-2:MAN_W];
   assign man_w      = data_q[MAN_W-1:0];
   assign exp_all1_w = &expf_w;
   assign exp_zero_w = ~|expf_w;
   assign man_zero_w = ~|man_w;

   // Highest set mantissa bit; only meaningful for a nonzero denormal.
   always_comb begin
      pos_w = '0;
      for (int i = 0; i < MAN_W; i++) begin
         if (man_w[i]) pos_w = SHW'(i);
      end
   end

   assign sh_w  = SHW'(MAN_W) - pos_w;
   assign sig_w = exp_zero_w ? ({1'b0, man_w} << sh_w) : {1'b1, man_w};
   assign ue_w  = exp_zero_w ? (EW'(1) - EW'(BIAS) - EW'(sh_w))
                             : (EW'(expf_w) - EW'(BIAS));

   // Odd exponents borrow one into the significand so the root halves exactly.
   assign rmant_w   = ue_w[0] ? {sig_w, 1'b0} : {1'b0, sig_w};
   assign ue_even_w = ue_w - EW'(ue_w[0]);
   assign half_w    = {ue_even_w[EW-1], ue_even_w[EW-1:1]};
   assign rexp_w    = EXP_W'(EW'(BIAS) + half_w);

   assign r_sh_w  = {rem_q[RW-3:0], rad_q[XW-1:XW-2]};
   assign trial_w = RW'({root_q, 2'b01});

   // Adding the guard at bit 0 carries into the fraction LSB when set.
   assign rnd_w    = {1'b0, root_q} + (QW+1)'(root_q[0] & ROUND_EN);
   assign unused_w = ^{rnd_w[QW-1], rnd_w[0], rem_q[RW-1:RW-2]};

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      rad_d      = rad_q;
      rem_d      = rem_q;
      root_d     = root_q;
      cnt_d      = cnt_q;
      exp_d      = exp_q;
      out_data_d = out_data_q;
      is_nan_d   = is_nan_q;
      is_pinf_d  = is_pinf_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.IN_VALID) begin
               data_d    = bus.IN_DATA;
               is_nan_d  = 1'b0;
               is_pinf_d = 1'b0;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            if (exp_all1_w && !man_zero_w) begin
               out_data_d            = data_q;
               out_data_d[MAN_W-1]   = 1'b1;
               is_nan_d              = 1'b1;
               state_d               = S_DONE;
            end else if (exp_zero_w && man_zero_w) begin
               out_data_d = data_q;
               state_d    = S_DONE;
            end else if (sign_w) begin
               out_data_d = QNAN;
               is_nan_d   = 1'b1;
               state_d    = S_DONE;
            end else if (exp_all1_w) begin
               out_data_d = data_q;
               is_pinf_d  = 1'b1;
               state_d    = S_DONE;
            end else begin
               rad_d   = {rmant_w, {QW{1'b0}}};
               rem_d   = '0;
               root_d  = '0;
               cnt_d   = '0;
               exp_d   = rexp_w;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            rad_d = rad_q << 2;
            if (r_sh_w >= trial_w) begin
               rem_d  = r_sh_w - trial_w;
               root_d = {root_q[QW-2:0], 1'b1};
            end else begin
               rem_d  = r_sh_w;
               root_d = {root_q[QW-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(QW - 1)) state_d = S_ROUND;
         end
         S_ROUND: begin
            out_data_d = {1'b0, exp_q + EXP_W'(rnd_w[QW]), rnd_w[QW-2:1]};
            state_d    = S_DONE;
         end
         S_DONE: begin
            if (bus.OUT_READY) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_IDLE;
         data_q     <= '0;
         rad_q      <= '0;
         rem_q      <= '0;
         root_q     <= '0;
         cnt_q      <= '0;
         exp_q      <= '0;
         out_data_q <= '0;
         is_nan_q   <= 1'b0;
         is_pinf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         rad_q      <= rad_d;
         rem_q      <= rem_d;
         root_q     <= root_d;
         cnt_q      <= cnt_d;
         exp_q      <= exp_d;
         out_data_q <= out_data_d;
         is_nan_q   <= is_nan_d;
         is_pinf_q  <= is_pinf_d;
      end
   end

   assign bus.IN_READY  = (state_q == S_IDLE);
   assign bus.OUT_VALID = (state_q == S_DONE);
   assign bus.BUSY      = (state_q != S_IDLE);
   assign bus.OUT_DATA  = out_data_q;
   assign bus.IS_NAN    = is_nan_q;
   assign bus.IS_PINF   = is_pinf_q;
   assign bus.IS_NINF   = 1'b0;
   assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_fp_sqrt_pipe.sv
// Directed bench for fp_sqrt_pipe at half precision; expectations follow the
// FP_SQRT_ROUND_EN setting of the build.
module tb_fp_sqrt_pipe;
   localparam int EXP_W = 5;
   localparam int MAN_W = 10;
   localparam int W     = 1 + EXP_W + MAN_W;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   fp_sqrt_pipe_if #(.W(W)) bus ();

   fp_sqrt_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus)
   );

`ifdef FP_SQRT_ROUND_EN
   localparam logic [W-1:0] EXP_3 = 16'h3EEE;
`else
   localparam logic [W-1:0] EXP_3 = 16'h3EED;
`endif

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs == exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Present one operand and return just after the accepting edge.
   task automatic start(input string tag, input logic [W-1:0] d);
      bus.IN_VALID = 1'b1;
      bus.IN_DATA  = d;
      @(posedge clk);
      #1;
      bus.IN_VALID = 1'b0;
      bus.IN_DATA  = 16'hFFFF;
      chk1({tag, " busy after accept"}, bus.BUSY, 1'b1);
      chk1({tag, " in_ready after accept"}, bus.IN_READY, 1'b0);
      chk1({tag, " is_nan cleared"}, bus.IS_NAN, 1'b0);
      chk1({tag, " is_pinf cleared"}, bus.IS_PINF, 1'b0);
   endtask

   task automatic wait_result(input string tag, input int lat, input logic [W-1:0] d,
                              input logic nan, input logic pinf);
      int k;
      k = 0;
      while (!bus.OUT_VALID && k < 40) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk_int({tag, " latency"}, k, lat);
      chk({tag, " data"}, bus.OUT_DATA, d);
      chk1({tag, " is_nan"}, bus.IS_NAN, nan);
      chk1({tag, " is_pinf"}, bus.IS_PINF, pinf);
      chk1({tag, " is_ninf"}, bus.IS_NINF, 1'b0);
   endtask

   task automatic handshake(input string tag, input logic [W-1:0] d);
      bus.OUT_READY = 1'b1;
      @(posedge clk);
      #1;
      bus.OUT_READY = 1'b0;
      chk1({tag, " out_valid after hs"}, bus.OUT_VALID, 1'b0);
      chk1({tag, " in_ready after hs"}, bus.IN_READY, 1'b1);
      chk({tag, " data held after hs"}, bus.OUT_DATA, d);
   endtask

   task automatic op(input string tag, input logic [W-1:0] din, input int lat,
                     input logic [W-1:0] d, input logic nan, input logic pinf);
      start(tag, din);
      wait_result(tag, lat, d, nan, pinf);
      handshake(tag, d);
   endtask

   task automatic chk_reset_state(input string tag);
      chk1({tag, " out_valid"}, bus.OUT_VALID, 1'b0);
      chk1({tag, " in_ready"}, bus.IN_READY, 1'b1);
      chk1({tag, " busy"}, bus.BUSY, 1'b0);
      chk({tag, " out_data"}, bus.OUT_DATA, '0);
      chk1({tag, " is_nan"}, bus.IS_NAN, 1'b0);
      chk1({tag, " is_pinf"}, bus.IS_PINF, 1'b0);
      chk_int({tag, " state"}, int'(bus.state_dbg), 0);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.IN_VALID  = 1'b0;
      bus.IN_DATA   = '0;
      bus.OUT_READY = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_state("reset");
      rst_n = 1'b1;

      op("sqrt4",     16'h4400, 14, 16'h4000, 1'b0, 1'b0);
      op("sqrt1",     16'h3C00, 14, 16'h3C00, 1'b0, 1'b0);
      op("sqrt3",     16'h4200, 14, EXP_3,    1'b0, 1'b0);
      op("min_den",   16'h0001, 14, 16'h0C00, 1'b0, 1'b0);
      op("max_norm",  16'h7BFF, 14, 16'h5BFF, 1'b0, 1'b0);
      op("neg_two",   16'hC400,  1, 16'hFE00, 1'b1, 1'b0);
      op("pos_inf",   16'h7C00,  1, 16'h7C00, 1'b0, 1'b1);
      op("neg_zero",  16'h8000,  1, 16'h8000, 1'b0, 1'b0);
      op("snan",      16'h7D00,  1, 16'h7F00, 1'b1, 1'b0);
      op("pos_zero",  16'h0000,  1, 16'h0000, 1'b0, 1'b0);
      op("neg_inf",   16'hFC00,  1, 16'hFE00, 1'b1, 1'b0);
      op("neg_den",   16'h8001,  1, 16'hFE00, 1'b1, 1'b0);
      op("den_odd",   16'h0200, 14, 16'h1DA8, 1'b0, 1'b0);

      // Backpressure with a competing operand held on the input.
      start("bp", 16'h4400);
      wait_result("bp", 14, 16'h4000, 1'b0, 1'b0);
      bus.IN_VALID = 1'b1;
      bus.IN_DATA  = 16'h3C00;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk1("bp stall out_valid", bus.OUT_VALID, 1'b1);
         chk("bp stall data", bus.OUT_DATA, 16'h4000);
         chk1("bp stall in_ready", bus.IN_READY, 1'b0);
      end
      bus.OUT_READY = 1'b1;
      @(posedge clk);
      #1;
      bus.OUT_READY = 1'b0;
      chk1("bp hs out_valid", bus.OUT_VALID, 1'b0);
      chk1("bp hs in_ready", bus.IN_READY, 1'b1);
      chk("bp hs data held", bus.OUT_DATA, 16'h4000);
      start("bp next", 16'h3C00);
      wait_result("bp next", 14, 16'h3C00, 1'b0, 1'b0);
      handshake("bp next", 16'h3C00);

      // Reset pulse during CALC.
      start("rst_calc", 16'h4200);
      repeat (5) @(posedge clk);
      #1;
      chk_int("rst_calc in calc", int'(bus.state_dbg), 2);
      rst_n = 1'b0;
      #1;
      chk_reset_state("rst_calc");
      @(posedge clk);
      #1;
      chk1("rst_calc held out_valid", bus.OUT_VALID, 1'b0);
      rst_n = 1'b1;
      op("after_rst", 16'h4400, 14, 16'h4000, 1'b0, 1'b0);

      // Reset pulse while a result waits in DONE.
      start("rst_done", 16'h7C00);
      wait_result("rst_done", 1, 16'h7C00, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_reset_state("rst_done");
      rst_n = 1'b1;
      op("after_rst2", 16'h4200, 14, EXP_3, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fp_sqrt_pipe.md
FP_SQRT_PIPE -- requirements
Module: fp_sqrt_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent field width (5 = half, 8 = single).
REQ-002 SHALL have parameter MAN_W, default 10, stored mantissa field width; data width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST_N  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports IN_VALID in 1, IN_READY out 1, IN_DATA in W (operand; sign, exponent, mantissa, MSB first).
REQ-006 SHALL have ports OUT_VALID out 1, OUT_READY in 1, OUT_DATA out W (result).
REQ-007 SHALL have ports IS_NAN out 1 (result NaN), IS_PINF out 1 (result +inf), IS_NINF out 1 (tied 0), BUSY out 1 (state != IDLE).

Function
REQ-008 SHALL implement FSM IDLE -> DECODE -> CALC -> ROUND -> DONE -> IDLE; IN_READY=1 only in IDLE.
REQ-009 SHALL capture IN_DATA on the edge where IN_VALID && IN_READY (edge 0) and enter DECODE.
REQ-010 SHALL in DECODE classify: NaN (exp all-1, man!=0), +inf, -inf, +0, -0, negative nonzero, denormal, normal.
REQ-011 SHALL for specials go DECODE -> DONE at edge 1: +inf -> +inf with IS_PINF=1; +/-0 -> same value; NaN -> same value with mantissa MSB set, IS_NAN=1; any negative nonzero (incl. -inf, -denormal) -> canonical qNaN {1, all-1 exponent, 1, zeros} (0xFE00 at defaults) with IS_NAN=1.
REQ-012 SHALL normalise denormals by leading-one shift, adjust the unbiased exponent, and make it even by a further 1-bit mantissa shift when odd.
REQ-013 SHALL compute result exponent as bias + floor(unbiased_exp/2) and root of the (MAN_W+2)-bit even-exponent significand by restoring digit recurrence, one result bit per cycle.
REQ-014 SHALL stay in CALC exactly MAN_W+2 cycles (hidden bit, MAN_W fraction bits, one guard bit), then enter ROUND.
REQ-015 SHALL in ROUND form OUT_DATA (sign 0, exponent, MAN_W fraction bits) per REQ-024/025; mantissa carry-out increments exponent and clears fraction.
REQ-016 SHALL assert OUT_VALID after edge MAN_W+4 for normal/denormal operands (14 at defaults) and after edge 1 for specials.
REQ-017 SHALL hold OUT_DATA, IS_NAN, IS_PINF stable in DONE until OUT_VALID && OUT_READY, then return to IDLE; outputs hold their value and OUT_VALID falls.
REQ-018 SHALL ignore IN_VALID and IN_DATA changes while not in IDLE; earliest next accept is the edge after the output handshake.
REQ-019 SHALL clear IS_NAN and IS_PINF on every accepting edge.
REQ-020 SHALL never produce a denormal or infinite result from a finite positive input.

Reset
REQ-021 SHALL on RST_N=0 immediately force state IDLE, OUT_VALID=0, OUT_DATA=0, IS_NAN=0, IS_PINF=0, BUSY=0, IN_READY=1, and clear all datapath registers.
REQ-022 SHALL abandon any in-flight operation on reset mid-CALC or mid-DONE with no output handshake.
REQ-023 SHALL accept a new operand on the first rising edge with RST_N=1 and IN_VALID=1.

Configuration
REQ-024 SHALL, when macro FP_SQRT_ROUND_EN is defined, round to nearest by adding the guard bit to the fraction (square-root ties cannot occur).
REQ-025 SHALL, without FP_SQRT_ROUND_EN, truncate (discard guard bit); latency unchanged in both builds.

Verification (defaults EXP_W=5, MAN_W=10)
REQ-026 SHALL cover 0x4400 (4.0) -> 0x4000, 0x3C00 -> 0x3C00, OUT_VALID 14 edges after accept, both builds.
REQ-027 SHALL cover 0x4200 (3.0) -> 0x3EEE with FP_SQRT_ROUND_EN, 0x3EED without.
REQ-028 SHALL cover 0x0001 (2^-24) -> 0x0C00, and 0x7BFF -> 0x5BFF (round) / 0x5BFF (trunc).
REQ-029 SHALL cover specials: 0xC400 -> 0xFE00 IS_NAN=1; 0x7C00 -> 0x7C00 IS_PINF=1; 0x8000 -> 0x8000; 0x7D00 -> 0x7F00 IS_NAN=1; each OUT_VALID 1 edge after accept.
REQ-030 SHALL cover backpressure: OUT_READY=0 for 5 cycles holds OUT_DATA, IN_READY=0; handshake then next accept on following edge.
REQ-031 SHALL cover RST_N pulse at CALC cycle 5: OUT_VALID stays 0, IN_READY=1 immediately, next operand 0x4400 -> 0x4000 correctly.
